game_status_tx: RTL and testbench



---
 rtl/game_pkg.sv | 36 +++
 rtl/game_status_tx_sclk_tick.sv | 31 +++
 rtl/game_status_tx.sv | 134 +++++++++++++
 tb/tb_game_status_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game-board status link: transmitter states,
// status-word field layout and default link geometry.
package game_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_HALF  = 2;

    // Status-word field layout, also used by the game FSM that builds the word.
    localparam int P1_SCORE_MSB   = 15;
    localparam int P1_SCORE_LSB   = 12;
    localparam int P2_SCORE_MSB   = 11;
    localparam int P2_SCORE_LSB   = 8;
    localparam int GAME_STATE_MSB = 7;
    localparam int GAME_STATE_LSB = 4;
    localparam int WINNER_MSB     = 3;
    localparam int WINNER_LSB     = 2;
    localparam int RSVD_MSB       = 1;
    localparam int RSVD_LSB       = 0;

    typedef struct packed {
        logic [3:0] p1_score;
        logic [3:0] p2_score;
        logic [3:0] game_state;
        logic [1:0] winner;
        logic [1:0] rsvd;
    } status_word_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD
    } state_t;

endpackage

// File: rtl/game_status_tx_sclk_tick.sv
// Phase divider: one-cycle tick every HALF clk cycles while running,
// restarted from zero on every accepted word.
module sclk_tick #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(HALF + 1);

    logic [CW-1:0] cnt;
    logic          last;

    assign last = (cnt == CW'(HALF - 1));
    assign tick = run && !restart && last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (restart || !run || last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/game_status_tx.sv
// SPI mode-0 style master that shifts one status word out MSB first over
// sclk/cs_n/sdo, fed by a valid/ready handshake from the game FSM.
module game_status_tx
    import game_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int HALF  = DEF_HALF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             sclk,
    output logic             cs_n,
    output logic             sdo,
    output logic             done
);

    localparam int BW = $clog2(WIDTH + 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [BW-1:0]    bitcnt, bitcnt_n;
    logic             sclk_n, cs_n_n, sdo_n, done_n, ready_n;
    logic             accept, tick, running;

    assign accept  = tx_valid && tx_ready;
    assign running = (state != IDLE);

    sclk_tick #(.HALF(HALF)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (accept),
        .run     (running),
        .tick    (tick)
    );

    // All link outputs are registered so sclk/cs_n/sdo never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bitcnt   <= '0;
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            sdo      <= 1'b0;
            done     <= 1'b0;
            tx_ready <= 1'b1;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bitcnt   <= bitcnt_n;
            sclk     <= sclk_n;
            cs_n     <= cs_n_n;
            sdo      <= sdo_n;
            done     <= done_n;
            tx_ready <= ready_n;
        end
    end

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bitcnt_n = bitcnt;
        sclk_n   = sclk;
        cs_n_n   = cs_n;
        sdo_n    = sdo;
        done_n   = 1'b0;
        ready_n  = tx_ready;
        case (state)
            IDLE: begin
                sclk_n  = 1'b0;
                cs_n_n  = 1'b1;
                sdo_n   = 1'b0;
                ready_n = 1'b1;
                if (accept) begin
                    shreg_n  = tx_data;
                    bitcnt_n = '0;
                    cs_n_n   = 1'b0;
                    sdo_n    = tx_data[WIDTH-1];
                    ready_n  = 1'b0;
                    state_n  = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_n   = 1'b1;
                    bitcnt_n = bitcnt + BW'(1);
                    state_n  = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    sclk_n  = 1'b0;
                    state_n = SHIFT_LO;
                    // Present the next bit on the falling edge; the last bit stays put.
                    if (bitcnt < BW'(WIDTH)) begin
                        shreg_n = {shreg[WIDTH-2:0], 1'b0};
                        sdo_n   = shreg[WIDTH-2];
                    end
                end
            end
            SHIFT_LO: begin
                if (tick) begin
                    if (bitcnt < BW'(WIDTH)) begin
                        sclk_n   = 1'b1;
                        bitcnt_n = bitcnt + BW'(1);
                        state_n  = SHIFT_HI;
                    end else begin
                        sdo_n   = 1'b0;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_n  = 1'b1;
                    done_n  = 1'b1;
                    ready_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                sclk_n  = 1'b0;
                cs_n_n  = 1'b1;
                sdo_n   = 1'b0;
                ready_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_game_status_tx.sv
// Directed bench for game_status_tx: a scoreboard of accepted words is checked
// against the bits seen on sdo at each sclk rise, plus frame timing.
module tb_game_status_tx;
    import game_pkg::*;

    localparam int WA = 16, HA = 2;
    localparam int WB = 2,  HB = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [WA-1:0] data_a = '0;
    logic          valid_a = 1'b0;
    logic          ready_a, sclk_a, cs_n_a, sdo_a, done_a;

    logic [WB-1:0] data_b = '0;
    logic          valid_b = 1'b0;
    logic          ready_b, sclk_b, cs_n_b, sdo_b, done_b;

    game_status_tx #(.WIDTH(WA), .HALF(HA)) dut_a (
        .clk(clk), .reset(rst_n), .tx_data(data_a), .tx_valid(valid_a),
        .tx_ready(ready_a), .sclk(sclk_a), .cs_n(cs_n_a), .sdo(sdo_a), .done(done_a)
    );

    game_status_tx #(.WIDTH(WB), .HALF(HB)) dut_b (
        .clk(clk), .reset(rst_n), .tx_data(data_b), .tx_valid(valid_b),
        .tx_ready(ready_b), .sclk(sclk_b), .cs_n(cs_n_b), .sdo(sdo_b), .done(done_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [WA-1:0] word;
        int            acc;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    int            rises = 0;
    int            first_rise = 0;
    int            last_done = -1;
    logic [WA-1:0] bits = '0;
    logic          prev_sclk = 1'b0;

    // Monitor for the 16-bit link: collect sdo at each sclk rise, score on done.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            rises     = 0;
            bits      = '0;
            prev_sclk = 1'b0;
        end else begin
            chk("sclk_while_deselected", 32'(sclk_a & cs_n_a), 32'd0);
            if (sclk_a && !prev_sclk) begin
                if (rises == 0) first_rise = cyc;
                rises++;
                bits = {bits[WA-2:0], sdo_a};
            end
            prev_sclk = sclk_a;
            if (done_a) begin
                last_done = cyc;
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("word", 32'(bits), 32'(e.word));
                    chk("rise_count", 32'(rises), 32'(WA));
                    chk("first_rise_edge", 32'(first_rise), 32'(e.acc + HA));
                    chk("done_edge", 32'(cyc), 32'(e.acc + HA * (2 * WA + 2)));
                    chk("cs_n_at_done", 32'(cs_n_a), 32'd1);
                end
                rises = 0;
            end
            if (valid_a && ready_a) sb.push_back('{data_a, cyc + 1});
        end
    end

    // Returns just after the accept edge; acc is that edge's number.
    task automatic wait_accept_a(output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(ready_a), 32'd1);
        acc = cyc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a();
        int n;
        n = 0;
        @(negedge clk);
        while (!done_a && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(done_a), 32'd1);
        #1;
    endtask

    task automatic wait_edge(input int edge_no);
        int n;
        n = 0;
        while (cyc < edge_no && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int acc, acc2, bad, n, accb, nr, done_e, rel;
        int rise_e[4];
        logic [WB-1:0] bb;
        logic pb;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", 32'(ready_a), 32'd1);
        chk("rst_cs_n", 32'(cs_n_a), 32'd1);
        chk("rst_sclk", 32'(sclk_a), 32'd0);
        chk("rst_sdo", 32'(sdo_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_b_ready", 32'(ready_b), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle quiet for 200 cycles
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (sclk_a || sdo_a || done_a || !cs_n_a || !ready_a) bad++;
        end
        chk("idle_quiet", 32'(bad), 32'd0);

        // Single frame 0xA5C3
        @(posedge clk);
        #1 data_a = 16'hA5C3; valid_a = 1'b1;
        wait_accept_a(acc);
        valid_a = 1'b0;
        wait_done_a();

        // Back-to-back 0x1234 then 0xFFFF with tx_valid held high
        @(posedge clk);
        #1 data_a = 16'h1234; valid_a = 1'b1;
        wait_accept_a(acc);
        data_a = 16'hFFFF;
        wait_accept_a(acc2);
        valid_a = 1'b0;
        chk("b2b_accept_after_done", 32'(acc2), 32'(last_done + 1));
        wait_done_a();

        // tx_data changes mid-frame; tx_ready must stay low to the end
        @(posedge clk);
        #1 data_a = 16'h00FF; valid_a = 1'b1;
        wait_accept_a(acc);
        valid_a = 1'b0;
        wait_edge(acc + 10);
        data_a = 16'hFF00;
        bad = 0;
        n = 0;
        @(negedge clk);
        while (!done_a && n < 100) begin
            if (ready_a) bad++;
            @(negedge clk);
            n++;
        end
        chk("ready_low_in_frame", 32'(bad), 32'd0);
        chk("ready_return", 32'(ready_a), 32'd1);
        chk("ready_return_edge", 32'(cyc), 32'(acc + 68));
        #1;

        // Reset at edge 25 of a frame
        @(posedge clk);
        #1 data_a = 16'hA5C3; valid_a = 1'b1;
        wait_accept_a(acc);
        valid_a = 1'b0;
        wait_edge(acc + 25);
        chk("pre_reset_cs_n", 32'(cs_n_a), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_cs_n", 32'(cs_n_a), 32'd1);
        chk("arst_sclk", 32'(sclk_a), 32'd0);
        chk("arst_sdo", 32'(sdo_a), 32'd0);
        chk("arst_tx_ready", 32'(ready_a), 32'd1);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a) bad++;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        repeat (80) begin
            @(negedge clk);
            if (done_a) bad++;
        end
        chk("no_done_after_abort", 32'(bad), 32'd0);
        @(posedge clk);
        #1 data_a = 16'h0001; valid_a = 1'b1;
        wait_accept_a(acc);
        valid_a = 1'b0;
        wait_done_a();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // WIDTH=2, HALF=1 instance
        @(posedge clk);
        #1 data_b = 2'b10; valid_b = 1'b1;
        @(negedge clk);
        chk("b_ready", 32'(ready_b), 32'd1);
        accb = cyc + 1;
        @(posedge clk);
        #1 valid_b = 1'b0;
        nr = 0;
        done_e = -1;
        bb = '0;
        pb = 1'b0;
        foreach (rise_e[k]) rise_e[k] = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            rel = cyc - accb;
            if (sclk_b && !pb) begin
                if (nr < 4) rise_e[nr] = rel;
                bb = {bb[0], sdo_b};
                nr++;
            end
            pb = sclk_b;
            if (done_b) done_e = rel;
        end
        chk("b_rise_count", 32'(nr), 32'd2);
        chk("b_rise0_edge", 32'(rise_e[0]), 32'd1);
        chk("b_rise1_edge", 32'(rise_e[1]), 32'd3);
        chk("b_bits", 32'(bb), 32'h2);
        chk("b_done_edge", 32'(done_e), 32'd6);
        chk("b_cs_n_idle", 32'(cs_n_b), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
